// File: rtl/servo_sequence_player.sv
// Steps through a position ROM and drives a frame-synchronous servo PWM.
// A new pulse width takes effect only at a frame boundary, so the servo never sees a partial frame.
module servo_sequence_player #(
  parameter int unsigned FRAME_MAX = 999999,
  parameter int unsigned LAST_ADDR = 255,
  parameter int unsigned LOOP      = 0,
  parameter int unsigned PW_MIN    = 50000,
  parameter int unsigned PW_STEP   = 196
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        start,
  input  logic        stop,
  input  logic        enabler,
  input  logic [7:0]  dataPosROM,
  output logic [19:0] counter,
  output logic [7:0]  address,
  output logic        pwm,
  output logic        busy,
  output logic        done
);

  localparam logic [19:0] FRAME_LAST = 20'(FRAME_MAX);
  localparam logic [7:0]  ADDR_LAST  = 8'(LAST_ADDR);
  localparam logic [19:0] PW_MIN_W   = 20'(PW_MIN);
  localparam logic [19:0] PW_STEP_W  = 20'(PW_STEP);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

  state_t      state_q, state_d;
  logic [19:0] counter_q, counter_d;
  logic [7:0]  address_q, address_d;
  logic        load_cnt_q, load_cnt_d;
  logic [7:0]  pos_reg_q, pos_reg_d;
  logic [19:0] pw_active_q, pw_active_d;
  logic        pwm_en_q, pwm_en_d;
  logic        pwm_q, pwm_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [19:0] pw_target;
  logic        frame_end;

  assign frame_end = (counter_q == FRAME_LAST);
  assign pw_target = PW_MIN_W + 20'(pos_reg_q) * PW_STEP_W;

  always_comb begin
    state_d    = state_q;
    address_d  = address_q;
    load_cnt_d = 1'b0;
    pos_reg_d  = pos_reg_q;
    pwm_en_d   = pwm_en_q;
    counter_d  = frame_end ? 20'd0 : counter_q + 20'd1;
    // Width stays 0 until the first position is latched, so no stale pulse leaks out.
    pw_active_d = (frame_end && pwm_en_q) ? pw_target : pw_active_q;
    pwm_d       = pwm_en_q && (counter_q < pw_active_q);

    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d   = LOAD;
          address_d = 8'd0;
        end
        // First cycle lets the ROM sample the address; data is valid in the second.
        LOAD: if (!load_cnt_q) begin
          load_cnt_d = 1'b1;
        end else begin
          pos_reg_d = dataPosROM;
          pwm_en_d  = 1'b1;
          state_d   = PLAY;
        end
        PLAY: if (enabler) begin
          if (address_q != ADDR_LAST) begin
            address_d = address_q + 8'd1;
            state_d   = LOAD;
          end else if (LOOP != 0) begin
            address_d = 8'd0;
            state_d   = LOAD;
          end else begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      counter_q   <= 20'd0;
      address_q   <= 8'd0;
      load_cnt_q  <= 1'b0;
      pos_reg_q   <= 8'd0;
      pw_active_q <= 20'd0;
      pwm_en_q    <= 1'b0;
      pwm_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      address_q   <= address_d;
      load_cnt_q  <= load_cnt_d;
      pos_reg_q   <= pos_reg_d;
      pw_active_q <= pw_active_d;
      pwm_en_q    <= pwm_en_d;
      pwm_q       <= pwm_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign counter = counter_q;
  assign address = address_q;
  assign pwm     = pwm_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
